// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths and data-memory arbiter enums
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ALEN = 32;

  localparam int ARB_NUM_MASTERS = 2;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } arb_master_t;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter for the single-port data BRAM
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin instead of fixed priority + starvation counter)
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [ALEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [3:0]      m0_be,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [ALEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [3:0]      m1_be,
  input  logic            m1_lock,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m1_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [ALEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic [XLEN-1:0] mem_rdata
);

  arb_state_t  state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic        rd_pending_q, rd_pending_d;
  arb_master_t rd_owner_q, rd_owner_d;
`ifdef ARB_ROUND_ROBIN_EN
  arb_master_t last_win_q, last_win_d;
`endif

  always_comb begin
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = '0;
    rd_pending_d = 1'b0;
    rd_owner_d   = rd_owner_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_win_d   = last_win_q;
`endif
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;

    // Grants are gated by reset so every output drops the instant rst rises.
    if (!rst) begin
      case (state_q)
        ARB: begin
`ifdef ARB_ROUND_ROBIN_EN
          if (m0_req && m1_req) begin
            if (last_win_q == M0) m1_gnt = 1'b1;
            else                  m0_gnt = 1'b1;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
`else
          if (m1_req && (!m0_req || (32'(wait_cnt_q) >= MAX_WAIT))) m1_gnt = 1'b1;
          else                                                      m0_gnt = m0_req;
`endif
          if (m1_gnt && m1_lock) state_d = LOCK;
        end
        LOCK: begin
          m1_gnt = m1_req;
          if (!m1_lock) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end

    if (m1_gnt) begin
      mem_en    = 1'b1;
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_be    = m1_be;
    end else if (m0_gnt) begin
      mem_en    = 1'b1;
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_be    = m0_be;
    end

    if (m0_gnt && !m0_we) begin
      rd_pending_d = 1'b1;
      rd_owner_d   = M0;
    end else if (m1_gnt && !m1_we) begin
      rd_pending_d = 1'b1;
      rd_owner_d   = M1;
    end

`ifdef ARB_ROUND_ROBIN_EN
    if (m0_gnt)      last_win_d = M0;
    else if (m1_gnt) last_win_d = M1;
`else
    // Count denied cycles of a waiting loader; any grant or idle cycle clears it.
    if (m1_req && !m1_gnt) wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      wait_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= M0;
`ifdef ARB_ROUND_ROBIN_EN
      last_win_q   <= M1;
`endif
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_win_q   <= last_win_d;
`endif
    end
  end

  assign m0_rvalid = rd_pending_q && (rd_owner_q == M0);
  assign m1_rvalid = rd_pending_q && (rd_owner_q == M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

  a_m0_hold: assert property (@(posedge clk) disable iff (rst)
    (m0_req && !m0_gnt) |=> (m0_req && $stable({m0_we, m0_addr, m0_wdata, m0_be})));
  a_m1_hold: assert property (@(posedge clk) disable iff (rst)
    (m1_req && !m1_gnt) |=> (m1_req && $stable({m1_we, m1_addr, m1_wdata, m1_be})));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized + directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM environment: 16 words, 1-cycle read latency
  logic [31:0] bram [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) bram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= bram[mem_addr[5:2]];
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration rules, word memory, pending read
  logic [31:0] ref_mem [16];
  bit          md_lock;
  int          md_starve;
  int          md_last;
  bit          md_pend;
  int          md_owner;
  logic [31:0] md_data;

  always @(negedge clk) begin
    int w;
    logic          e_we;
    logic [31:0]   e_addr, e_wdata;
    logic [3:0]    e_be;
    if (rst) begin
      chk1("rst_m0_gnt", m0_gnt, 1'b0);
      chk1("rst_m1_gnt", m1_gnt, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
      chk1("rst_m1_rvalid", m1_rvalid, 1'b0);
      chk32("rst_m0_rdata", m0_rdata, 32'h0);
      chk32("rst_m1_rdata", m1_rdata, 32'h0);
      md_lock = 0; md_starve = 0; md_last = 1; md_pend = 0; md_owner = 0; md_data = '0;
    end else begin
      w = -1;
      if (md_lock)                  w = m1_req ? 1 : -1;
      else if (m0_req && m1_req)    w = RR ? ((md_last == 0) ? 1 : 0) : ((md_starve >= MAX_WAIT) ? 1 : 0);
      else if (m0_req)              w = 0;
      else if (m1_req)              w = 1;
      e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
      if (w == 0) begin e_we = m0_we; e_addr = m0_addr; e_wdata = m0_wdata; e_be = m0_be; end
      if (w == 1) begin e_we = m1_we; e_addr = m1_addr; e_wdata = m1_wdata; e_be = m1_be; end
      chk1("m0_gnt", m0_gnt, w == 0);
      chk1("m1_gnt", m1_gnt, w == 1);
      chk1("mem_en", mem_en, w >= 0);
      chk1("mem_we", mem_we, e_we);
      chk32("mem_addr", mem_addr, e_addr);
      chk32("mem_wdata", mem_wdata, e_wdata);
      chk32("mem_be", {28'd0, mem_be}, {28'd0, e_be});
      chk1("m0_rvalid", m0_rvalid, md_pend && md_owner == 0);
      chk1("m1_rvalid", m1_rvalid, md_pend && md_owner == 1);
      chk32("m0_rdata", m0_rdata, (md_pend && md_owner == 0) ? md_data : 32'h0);
      chk32("m1_rdata", m1_rdata, (md_pend && md_owner == 1) ? md_data : 32'h0);
      md_pend = 0;
      if (w >= 0) begin
        if (e_we) begin
          for (int b = 0; b < 4; b++)
            if (e_be[b]) ref_mem[e_addr[5:2]][8*b +: 8] = e_wdata[8*b +: 8];
        end else begin
          md_pend = 1; md_owner = w; md_data = ref_mem[e_addr[5:2]];
        end
        md_last = w;
      end
      if (md_lock)                   md_lock = m1_lock;
      else if (w == 1 && m1_lock)    md_lock = 1;
      if (m1_req && w != 1) md_starve = (md_starve < 15) ? md_starve + 1 : 15;
      else                  md_starve = 0;
    end
  end

  task automatic set_m0(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; m0_be = b;
  endtask

  task automatic set_m1(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input bit l);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; m1_be = b; m1_lock = l;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit g0, g1;
    for (int i = 0; i < 16; i++) begin
      bram[i]    = 32'h1000_0000 + 32'h0101_0101 * i;
      ref_mem[i] = 32'h1000_0000 + 32'h0101_0101 * i;
    end
    bram[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
    mem_rdata = '0;
    rst = 1'b1;
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // m0-only read of 0x10
    set_m0(1, 0, 32'h10, 0, 4'hF);
    @(negedge clk); chk1("t1_gnt", m0_gnt, 1'b1);
    next_cycle(); set_m0(0, 0, 0, 0, 0);
    @(negedge clk);
    chk1("t1_rvalid", m0_rvalid, 1'b1);
    chk32("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk1("t1_m1_rvalid", m1_rvalid, 1'b0);
    next_cycle();

    // back-to-back reads from different masters
    set_m0(1, 0, 32'h04, 0, 4'hF);
    @(negedge clk); chk1("t4_m0_gnt", m0_gnt, 1'b1);
    next_cycle(); set_m0(0, 0, 0, 0, 0); set_m1(1, 0, 32'h08, 0, 4'hF, 0);
    @(negedge clk);
    chk1("t4_m1_gnt", m1_gnt, 1'b1);
    chk1("t4_m0_rvalid", m0_rvalid, 1'b1);
    chk32("t4_m0_rdata", m0_rdata, 32'h1101_0101);
    next_cycle(); set_m1(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk1("t4_m1_rvalid", m1_rvalid, 1'b1);
    chk32("t4_m1_rdata", m1_rdata, 32'h1202_0202);
    chk1("t4_m0_rvalid_off", m0_rvalid, 1'b0);
    next_cycle();

    // both masters requesting continuously
    set_m0(1, 0, 32'h00, 0, 4'hF); set_m1(1, 0, 32'h0C, 0, 4'hF, 0);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk1("t6_m0_gnt", m0_gnt, (k % 2) == 1);
      chk1("t6_m1_gnt", m1_gnt, (k % 2) == 0);
      next_cycle();
    end
    set_m1(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk1("t6_tail_m0", m0_gnt, 1'b1);
    next_cycle(); set_m0(0, 0, 0, 0, 0);
`else
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk1("t2_m0_gnt", m0_gnt, k != 9);
      chk1("t2_m1_gnt", m1_gnt, k == 9);
      next_cycle();
    end
    set_m0(0, 0, 0, 0, 0);
    @(negedge clk); chk1("t2_tail_m1", m1_gnt, 1'b1);
    next_cycle(); set_m1(0, 0, 0, 0, 0, 0);
`endif
    @(negedge clk); next_cycle();

    // locked write burst from m1 while m0 waits
    set_m1(1, 1, 32'h20, 32'h0000_00AA, 4'hF, 1);
    @(negedge clk); chk1("t3_m1_gnt", m1_gnt, 1'b1); chk1("t3_we", mem_we, 1'b1);
    next_cycle(); set_m0(1, 0, 32'h04, 0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("t3_lock_m0_gnt", m0_gnt, 1'b0);
      chk1("t3_lock_m1_gnt", m1_gnt, 1'b1);
      next_cycle();
    end
    set_m1(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk1("t3_release_m0_gnt", m0_gnt, 1'b0);
    next_cycle();
    @(negedge clk); chk1("t3_after_m0_gnt", m0_gnt, 1'b1); chk1("t3_after_we", mem_we, 1'b0);
    next_cycle(); set_m0(0, 0, 0, 0, 0);

    // async reset while locked with a read pending
    set_m1(1, 0, 32'h08, 0, 4'hF, 1);
    @(negedge clk); chk1("t5_m1_gnt", m1_gnt, 1'b1);
    next_cycle();
    rst = 1'b1;
    #1;
    chk1("t5_m1_gnt_rst", m1_gnt, 1'b0);
    chk1("t5_m1_rvalid_rst", m1_rvalid, 1'b0);
    chk1("t5_mem_en_rst", mem_en, 1'b0);
    chk32("t5_m1_rdata_rst", m1_rdata, 32'h0);
    set_m1(0, 0, 0, 0, 0, 0);
    @(negedge clk); next_cycle();
    rst = 1'b0;
    set_m0(1, 0, 32'h10, 0, 4'hF);
    @(negedge clk); chk1("t5_m0_gnt_after", m0_gnt, 1'b1);
    next_cycle(); set_m0(0, 0, 0, 0, 0);

    // randomized traffic; a denied request is held unchanged
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); g0 = m0_gnt; g1 = m1_gnt;
      next_cycle();
      if (!(m0_req && !g0))
        set_m0(($urandom % 3) != 0, $urandom % 2, {26'd0, 4'($urandom_range(15)), 2'b00},
               $urandom, 4'($urandom));
      if (!(m1_req && !g1))
        set_m1(($urandom % 2) != 0, $urandom % 2, {26'd0, 4'($urandom_range(15)), 2'b00},
               $urandom, 4'($urandom), m1_lock);
      m1_lock = ($urandom % 3) == 0;
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
